// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, FSM state encoding and LFSR constants for the DDS phase generator.
package dds_pkg;
    localparam int FREQ_WORD_WIDTH  = 24;
    localparam int PHASE_WORD_WIDTH = 8;
    localparam int BITWIDTH         = 16;
    typedef enum logic [1:0] {IDLE, RUN, SWEEP} state_t;
    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/dds_lfsr16.sv
// dds_lfsr16: 16-bit Galois LFSR with enable and seed load; reset reloads the package seed.
import dds_pkg::*;
module dds_lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);
    logic [15:0] r_lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lfsr <= LFSR_SEED;
        else if (i_load)
            r_lfsr <= i_seed;
        else if (i_en)
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
    assign o_state = r_lfsr;
endmodule

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase-coherent DDS phase accumulator with per-wrap linear frequency sweep.
// Defining DDS_PHASE_DITHER_EN adds LFSR dither to the address path only.
import dds_pkg::*;
module dds_phase_gen #(
    parameter int ACC_WIDTH   = FREQ_WORD_WIDTH,
    parameter int PHASE_WIDTH = PHASE_WORD_WIDTH,
    parameter int STEP_WIDTH  = BITWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ACC_WIDTH-1:0]   cfg_freq,
    input  logic [PHASE_WIDTH-1:0] cfg_phase,
    input  logic                   cfg_sweep,
    input  logic [STEP_WIDTH-1:0]  sweep_step,
    input  logic [ACC_WIDTH-1:0]   sweep_stop,
    output logic [PHASE_WIDTH-1:0] addr,
    output logic                   addr_valid,
    output logic                   wrap,
    output logic                   sweep_done
);
    state_t r_state, w_next;
    logic [ACC_WIDTH-1:0]   r_acc, r_freq, r_stop, r_sh_freq, r_sh_stop;
    logic [STEP_WIDTH-1:0]  r_step, r_sh_step;
    logic [PHASE_WIDTH-1:0] r_phase, r_sh_phase, r_addr;
    logic                   r_sh_sweep, r_pending, r_arm, r_addr_valid, r_wrap, r_sweep_done;
    logic [ACC_WIDTH:0]     w_sum, w_nf;
    logic [ACC_WIDTH-1:0]   w_sweep_freq, w_addr_acc;
    logic                   w_active, w_carry, w_xfer, w_apply, w_arm, w_sweep_hit, w_done;

    assign w_active     = (r_state != IDLE) && en;
    assign w_sum        = {1'b0, r_acc} + {1'b0, r_freq};
    assign w_carry      = w_active && w_sum[ACC_WIDTH];
    assign w_xfer       = cfg_valid && !r_pending;
    assign w_apply      = r_pending && ((r_state == IDLE) || w_carry);
    assign w_arm        = w_apply ? r_sh_sweep : r_arm;
    // one extra bit keeps freq + step from wrapping before the clamp
    assign w_nf         = {1'b0, r_freq} + (ACC_WIDTH+1)'(r_step);
    assign w_sweep_freq = (w_nf >= {1'b0, r_stop}) ? r_stop : w_nf[ACC_WIDTH-1:0];
    assign w_sweep_hit  = (r_state == SWEEP) && w_carry && !r_pending;
    assign w_done       = w_sweep_hit && (w_sweep_freq == r_stop);

`ifdef DDS_PHASE_DITHER_EN
    localparam logic [ACC_WIDTH-1:0] DITHER_MASK = {{PHASE_WIDTH{1'b0}}, {(ACC_WIDTH-PHASE_WIDTH){1'b1}}};
    logic [15:0] w_lfsr;
    dds_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_state != IDLE),
        .i_load  (1'b0),
        .i_seed  (LFSR_SEED),
        .o_state (w_lfsr)
    );
    assign w_addr_acc = r_acc + (ACC_WIDTH'(w_lfsr) & DITHER_MASK);
`else
    assign w_addr_acc = r_acc;
`endif

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = en ? (w_arm ? SWEEP : RUN) : IDLE;
        else if (!en)
            w_next = IDLE;
        else if (w_apply)
            w_next = r_sh_sweep ? SWEEP : RUN;
        else if (w_done)
            w_next = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_freq       <= '0;
            r_phase      <= '0;
            r_step       <= '0;
            r_stop       <= '0;
            r_sh_freq    <= '0;
            r_sh_phase   <= '0;
            r_sh_sweep   <= 1'b0;
            r_sh_step    <= '0;
            r_sh_stop    <= '0;
            r_pending    <= 1'b0;
            r_arm        <= 1'b0;
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            r_wrap       <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            if (w_active)
                r_acc <= w_sum[ACC_WIDTH-1:0];
            r_addr       <= w_addr_acc[ACC_WIDTH-1 -: PHASE_WIDTH] + r_phase;
            r_addr_valid <= (r_state != IDLE);
            r_wrap       <= w_carry;
            r_sweep_done <= w_done;
            r_arm        <= w_done ? 1'b0 : w_arm;
            if (w_xfer) begin
                r_sh_freq  <= cfg_freq;
                r_sh_phase <= cfg_phase;
                r_sh_sweep <= cfg_sweep;
                r_sh_step  <= sweep_step;
                r_sh_stop  <= sweep_stop;
            end
            // capture needs !pending and apply needs pending, so they never collide
            r_pending <= w_xfer || (r_pending && !w_apply);
            if (w_apply) begin
                r_freq  <= r_sh_freq;
                r_phase <= r_sh_phase;
                r_step  <= r_sh_step;
                r_stop  <= r_sh_stop;
            end else if (w_sweep_hit)
                r_freq <= w_sweep_freq;
        end
    end

    assign cfg_ready  = !r_pending;
    assign addr       = r_addr;
    assign addr_valid = r_addr_valid;
    assign wrap       = r_wrap;
    assign sweep_done = r_sweep_done;
endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: directed stimulus against a cycle-level behavioural model of the phase generator.
module tb_dds_phase_gen;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0, cfg_sweep = 1'b0;
    logic [23:0] cfg_freq = '0, sweep_stop = '0;
    logic [7:0]  cfg_phase = '0;
    logic [15:0] sweep_step = '0;
    logic        cfg_ready, addr_valid, wrap, sweep_done;
    logic [7:0]  addr;
    int checks = 0, failures = 0;
    bit chk_on = 1'b0;

    dds_phase_gen dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_sweep(cfg_sweep),
        .sweep_step(sweep_step), .sweep_stop(sweep_stop), .addr(addr),
        .addr_valid(addr_valid), .wrap(wrap), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    // with dither the address may sit one LSB above the plain truncation
    task automatic chk_near(input string n, input logic [7:0] a, input logic [7:0] e);
        logic [7:0] d;
        bit ok;
        d = a - e;
`ifdef DDS_PHASE_DITHER_EN
        ok = (d == 8'h00) || (d == 8'h01) || (d == 8'hFF);
`else
        ok = (d == 8'h00) && !$isunknown(a);
`endif
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    // model state: mode 0=idle 1=run 2=sweep
    int unsigned m_acc, m_freq, m_phase, m_step, m_stop, s_freq, s_phase, s_step, s_stop;
    int unsigned m_addr, nf;
    int m_mode, old_mode;
    bit s_sweep, m_pend, m_arm, m_av, m_wrap, m_done, go, carry, apply, xfer;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc = 0; m_freq = 0; m_phase = 0; m_step = 0; m_stop = 0;
            s_freq = 0; s_phase = 0; s_step = 0; s_stop = 0; s_sweep = 0;
            m_pend = 0; m_arm = 0; m_mode = 0; m_addr = 0; m_av = 0; m_wrap = 0; m_done = 0;
        end else begin
            old_mode = m_mode;
            go = (old_mode != 0) && en;
            carry = go && (m_acc + m_freq >= 32'h0100_0000);
            apply = m_pend && (old_mode == 0 || carry);
            xfer = cfg_valid && !m_pend;
            m_addr = ((m_acc >> 16) + m_phase) % 256;
            m_av = (old_mode != 0);
            m_wrap = carry;
            m_done = 0;
            if (go) m_acc = (m_acc + m_freq) % 32'h0100_0000;
            if (apply) begin
                m_freq = s_freq; m_phase = s_phase; m_step = s_step; m_stop = s_stop;
                m_pend = 0; m_arm = s_sweep;
                if (old_mode != 0) m_mode = s_sweep ? 2 : 1;
            end else if (old_mode == 2 && carry) begin
                nf = m_freq + m_step;
                m_freq = (nf >= m_stop) ? m_stop : nf;
                if (m_freq == m_stop) begin
                    m_done = 1; m_mode = 1; m_arm = 0;
                end
            end
            if (old_mode == 0) m_mode = en ? (m_arm ? 2 : 1) : 0;
            else if (!en) m_mode = 0;
            if (xfer) begin
                s_freq = cfg_freq; s_phase = cfg_phase; s_sweep = cfg_sweep;
                s_step = sweep_step; s_stop = sweep_stop; m_pend = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_on && !rst) begin
            chk_near("m_addr", addr, m_addr[7:0]);
            chk("m_addr_valid", addr_valid, m_av);
            chk("m_wrap", wrap, m_wrap);
            chk("m_sweep_done", sweep_done, m_done);
            chk("m_cfg_ready", cfg_ready, !m_pend);
        end
    end

    task automatic cfg(input logic [23:0] f, input logic [7:0] p, input logic s,
                       input logic [15:0] st, input logic [23:0] sp);
        cfg_freq = f; cfg_phase = p; cfg_sweep = s; sweep_step = st; sweep_stop = sp;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && !cfg_ready; i++) @(negedge clk);
        chk("ready_timeout", cfg_ready, 1'b1);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sweep_done) n++;
        end
    endtask

    initial begin
        int n;
        logic [7:0] a0, d;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_addr", addr, 8'h00);
        chk("rst_addr_valid", addr_valid, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_sweep_done", sweep_done, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk_on = 1'b1;
        // basic run
        cfg(24'h010000, 8'h00, 1'b0, 16'h0, 24'h0);
        chk("idle_pending", cfg_ready, 1'b0);
        @(negedge clk);
        chk("idle_applied", cfg_ready, 1'b1);
        en = 1'b1;
        @(negedge clk);
        chk("valid_lat0", addr_valid, 1'b0);
        @(negedge clk);
        chk("valid_lat1", addr_valid, 1'b1);
        chk_near("first_addr", addr, 8'h00);
        repeat (255) @(negedge clk);
        chk_near("addr_ff", addr, 8'hFF);
        chk("wrap_at_256", wrap, 1'b1);
        @(negedge clk);
        chk_near("addr_rollover", addr, 8'h00);
        chk("wrap_one_cycle", wrap, 1'b0);
        // phase-coherent update
        cfg(24'h020000, 8'h40, 1'b0, 16'h0, 24'h0);
        chk("run_pending", cfg_ready, 1'b0);
        for (int i = 0; i < 300 && !wrap; i++) @(negedge clk);
        chk("wrap_timeout", wrap, 1'b1);
        chk("apply_at_wrap", cfg_ready, 1'b1);
        chk_near("pre_apply_addr", addr, 8'hFF);
        @(negedge clk);
        chk_near("new_phase_addr", addr, 8'h40);
        @(negedge clk);
        chk_near("new_freq_addr", addr, 8'h42);
        // pause
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("pause_valid", addr_valid, 1'b0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        // sweep 0x100000 -> 0x108000 -> 0x110000
        cfg(24'h100000, 8'h00, 1'b1, 16'h8000, 24'h110000);
        wait_ready(300);
        count_done(200, n);
        chk("sweep_done_once", n, 1);
        a0 = addr;
        @(negedge clk);
        d = addr - a0;
        chk_near("sweep_final_step", d, 8'h11);
        // stop below start frequency: done on first wrap, freq clamps to stop
        cfg(24'h040000, 8'h00, 1'b1, 16'h0100, 24'h030000);
        wait_ready(100);
        count_done(100, n);
        chk("stop_below_done", n, 1);
        a0 = addr;
        @(negedge clk);
        d = addr - a0;
        chk_near("stop_below_step", d, 8'h03);
        // freq=0 freezes the accumulator and holds a pending config
        en = 1'b0;
        repeat (2) @(negedge clk);
        cfg(24'h000000, 8'h00, 1'b0, 16'h0, 24'h0);
        @(negedge clk);
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wrap) n++;
        end
        chk("zero_freq_no_wrap", n, 0);
        cfg(24'h010000, 8'h00, 1'b0, 16'h0, 24'h0);
        repeat (20) @(negedge clk);
        chk("zero_freq_held", cfg_ready, 1'b0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("zero_freq_idle_apply", cfg_ready, 1'b1);
        // reset mid-sweep
        cfg(24'h010000, 8'h10, 1'b1, 16'h0000, 24'h200000);
        @(negedge clk);
        en = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_addr", addr, 8'h00);
        chk("midrst_valid", addr_valid, 1'b0);
        chk("midrst_wrap", wrap, 1'b0);
        chk("midrst_done", sweep_done, 1'b0);
        chk("midrst_ready", cfg_ready, 1'b1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
